iod_delay_line_seq: RTL

- Sequences the dynamic delay lines of a bank of DDR4 address/command IOD lanes (such as BA0/BA1), which run in dynamic delay-line mode.
- Takes one adjust command at a time from the training/calibration logic over a valid/ready handshake.
- Drives each lane's DELAY_LINE_MOVE / DELAY_LINE_DIRECTION / DELAY_LINE_LOAD with the required setup and settle spacing.
- Tracks each lane's current tap and honours the IOD out-of-range flags.

---
 rtl/iod_dly_pkg.sv | 28 ++
 rtl/iod_dly_tap_tracker.sv | 32 +++
 rtl/iod_delay_line_seq.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/iod_dly_pkg.sv
// Shared op codes, completion status codes and sequencer states for the
// IOD dynamic delay-line sequencer.
package iod_dly_pkg;

   typedef enum logic [1:0] {
      OP_NOP  = 2'b00,
      OP_MOVE = 2'b01,
      OP_LOAD = 2'b10,
      OP_ILL  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_OK     = 2'b00,
      ST_OOR    = 2'b01,
      ST_BADCMD = 2'b10
   } status_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_PULSE,
      S_SETTLE,
      S_LPULSE,
      S_LSETTLE,
      S_FIN
   } state_e;

endpackage

// File: rtl/iod_dly_tap_tracker.sv
// Mirror of one IOD lane's delay-line tap: load, saturating step up/down,
// and end-of-range flags.
module iod_dly_tap_tracker #(
   parameter int unsigned TAP_W    = 8,
   parameter int unsigned LOAD_TAP = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             dec,
   input  logic             load,
   output logic [TAP_W-1:0] tap,
   output logic             at_max,
   output logic             at_min
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tap <= TAP_W'(LOAD_TAP);
      end else if (load) begin
         tap <= TAP_W'(LOAD_TAP);
      end else if (inc && (tap != '1)) begin
         tap <= tap + TAP_W'(1);
      end else if (dec && (tap != '0)) begin
         tap <= tap - TAP_W'(1);
      end
   end

   assign at_max = (tap == '1);
   assign at_min = (tap == '0);

endmodule

// File: rtl/iod_delay_line_seq.sv
// Sequences MOVE/DIRECTION/LOAD pulses to a bank of IOD delay lines, one
// handshaked command at a time, keeping a tracked tap per lane.
module iod_delay_line_seq
   import iod_dly_pkg::*;
#(
   parameter int unsigned NUM_LANES     = 2,
   parameter int unsigned LANE_W        = 1,
   parameter int unsigned STEP_W        = 8,
   parameter int unsigned TAP_W         = 8,
   parameter int unsigned SETTLE_CYCLES = 3,
   parameter int unsigned LOAD_TAP      = 1
) (
   input  logic                       FAB_CLK,
   input  logic                       ARST_N,
   input  logic                       CMD_VALID,
   output logic                       CMD_READY,
   input  logic [1:0]                 CMD_OP,
   input  logic [LANE_W-1:0]          CMD_LANE,
   input  logic                       CMD_DIR,
   input  logic [STEP_W-1:0]          CMD_STEPS,
   output logic                       DONE,
   output logic [1:0]                 DONE_STATUS,
   output logic [STEP_W-1:0]          DONE_STEPS,
   output logic [NUM_LANES*TAP_W-1:0] TAP_POS,
   output logic [NUM_LANES-1:0]       DELAY_LINE_MOVE,
   output logic [NUM_LANES-1:0]       DELAY_LINE_DIRECTION,
   output logic [NUM_LANES-1:0]       DELAY_LINE_LOAD,
   input  logic [NUM_LANES-1:0]       DELAY_LINE_OUT_OF_RANGE
);

   localparam int unsigned      CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [TAP_W-1:0] TAP_MAX_M1  = ~TAP_W'(1);
   localparam logic [TAP_W-1:0] TAP_MIN_P1  = TAP_W'(1);

   state_e               state_q, state_d;
   status_e              status_q, status_d;
   logic [NUM_LANES-1:0] lane_oh_q, lane_oh_d;
   logic [NUM_LANES-1:0] dir_line_q, dir_line_d;
   logic                 cdir_q, cdir_d;
   logic [STEP_W-1:0]    left_q, left_d;
   logic [STEP_W-1:0]    moved_q, moved_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   logic [NUM_LANES-1:0] cmd_oh;
   logic [NUM_LANES-1:0] tap_inc, tap_dec, tap_load;
   logic [NUM_LANES-1:0] at_max, at_min;
   logic [TAP_W-1:0]     tap_arr [NUM_LANES];
   logic [TAP_W-1:0]     tap_sel;
   logic                 max_sel, min_sel, oor_sel;
   logic                 bad_cmd, bound_now, bound_next;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      assign cmd_oh[i] = (CMD_LANE == LANE_W'(i));

      iod_dly_tap_tracker #(
         .TAP_W    (TAP_W),
         .LOAD_TAP (LOAD_TAP)
      ) u_tap (
         .clk    (FAB_CLK),
         .rst_n  (ARST_N),
         .inc    (tap_inc[i]),
         .dec    (tap_dec[i]),
         .load   (tap_load[i]),
         .tap    (tap_arr[i]),
         .at_max (at_max[i]),
         .at_min (at_min[i])
      );

      assign TAP_POS[i*TAP_W +: TAP_W] = tap_arr[i];
   end

   always_comb begin
      tap_sel = '0;
      max_sel = 1'b0;
      min_sel = 1'b0;
      oor_sel = 1'b0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
         if (lane_oh_q[i]) begin
            tap_sel = tap_arr[i];
            max_sel = at_max[i];
            min_sel = at_min[i];
            oor_sel = DELAY_LINE_OUT_OF_RANGE[i];
         end
      end
   end

   assign bad_cmd    = (CMD_OP == OP_ILL) || (32'(CMD_LANE) >= NUM_LANES);
   assign bound_now  = cdir_q ? max_sel : min_sel;
   // The tap updates on the same edge that decides the next pulse, so the
   // range check looks one step ahead instead of at the stale counter.
   assign bound_next = cdir_q ? (tap_sel == TAP_MAX_M1) : (tap_sel == TAP_MIN_P1);

   always_comb begin
      state_d    = state_q;
      status_d   = status_q;
      lane_oh_d  = lane_oh_q;
      dir_line_d = dir_line_q;
      cdir_d     = cdir_q;
      left_d     = left_q;
      moved_d    = moved_q;
      cnt_d      = cnt_q;
      tap_inc    = '0;
      tap_dec    = '0;
      tap_load   = '0;

      case (state_q)
         S_IDLE: begin
            if (CMD_VALID) begin
               lane_oh_d = cmd_oh;
               cdir_d    = CMD_DIR;
               left_d    = CMD_STEPS;
               moved_d   = '0;
               status_d  = ST_OK;
               if (bad_cmd) begin
                  status_d = ST_BADCMD;
                  state_d  = S_FIN;
               end else begin
                  case (op_e'(CMD_OP))
                     OP_MOVE: begin
                        if (CMD_STEPS == '0) begin
                           state_d = S_FIN;
                        end else begin
                           dir_line_d = (dir_line_q & ~cmd_oh) | (CMD_DIR ? cmd_oh : '0);
                           state_d    = S_SETUP;
                        end
                     end
                     OP_LOAD: state_d = S_LPULSE;
                     default: state_d = S_FIN;
                  endcase
               end
            end
         end

         S_SETUP: begin
            if (bound_now) begin
               status_d = ST_OOR;
               state_d  = S_FIN;
            end else begin
               state_d = S_PULSE;
            end
         end

         S_PULSE: begin
            cnt_d   = SETTLE_LAST;
            state_d = S_SETTLE;
         end

         S_SETTLE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (oor_sel) begin
               status_d = ST_OOR;
               state_d  = S_FIN;
            end else begin
               tap_inc = cdir_q ? lane_oh_q : '0;
               tap_dec = cdir_q ? '0 : lane_oh_q;
               moved_d = moved_q + STEP_W'(1);
               left_d  = left_q - STEP_W'(1);
               if (left_q == STEP_W'(1)) begin
                  state_d = S_FIN;
               end else if (bound_next) begin
                  status_d = ST_OOR;
                  state_d  = S_FIN;
               end else begin
                  state_d = S_PULSE;
               end
            end
         end

         S_LPULSE: begin
            tap_load = lane_oh_q;
            cnt_d    = SETTLE_LAST;
            state_d  = S_LSETTLE;
         end

         S_LSETTLE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               state_d = S_FIN;
            end
         end

         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge FAB_CLK or negedge ARST_N) begin
      if (!ARST_N) begin
         state_q    <= S_IDLE;
         status_q   <= ST_OK;
         lane_oh_q  <= '0;
         dir_line_q <= '0;
         cdir_q     <= 1'b0;
         left_q     <= '0;
         moved_q    <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         status_q   <= status_d;
         lane_oh_q  <= lane_oh_d;
         dir_line_q <= dir_line_d;
         cdir_q     <= cdir_d;
         left_q     <= left_d;
         moved_q    <= moved_d;
         cnt_q      <= cnt_d;
      end
   end

   assign CMD_READY            = (state_q == S_IDLE);
   assign DONE                 = (state_q == S_FIN);
   assign DONE_STATUS          = DONE ? status_q : ST_OK;
   assign DONE_STEPS           = DONE ? moved_q : '0;
   assign DELAY_LINE_MOVE      = (state_q == S_PULSE) ? lane_oh_q : '0;
   assign DELAY_LINE_LOAD      = (state_q == S_LPULSE) ? lane_oh_q : '0;
   assign DELAY_LINE_DIRECTION = dir_line_q;

endmodule
